// File: rtl/psum_reduce_accum.sv
// psum_reduce_accum: joins masked column psum streams, reduces them per lane in a registered stage,
// then accumulates pass groups (saturating or wrapping) and emits one vector per group.
module psum_reduce_accum #(
  parameter int NUM_COL    = 4,
  parameter int LANES      = 18,
  parameter int PSUM_WIDTH = 16,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  input  logic [NUM_COL-1:0]                  cfg_col_mask,
  input  logic [7:0]                          cfg_pass_num,
  input  logic [15:0]                         cfg_out_num,
  input  logic                                cfg_sat_en,
  input  logic [NUM_COL-1:0]                  col_valid,
  input  logic [NUM_COL*LANES*PSUM_WIDTH-1:0] col_data,
  output logic [NUM_COL-1:0]                  col_ready,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LANES*ACC_WIDTH-1:0]          out_data,
  output logic                                out_last,
  output logic                                sat_flag,
  output logic                                finish
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                 r_state;
  logic [NUM_COL-1:0]     r_mask;
  logic [7:0]             r_pass_num;
  logic [15:0]            r_out_num;
  logic                   r_sat_en;
  logic [23:0]            r_total;
  logic [23:0]            r_issued;
  logic [7:0]             r_pass_cnt;
  logic [15:0]            r_out_cnt;
  logic                   r_s1_valid;
  logic [ACC_WIDTH-1:0]   r_s1_data [LANES];
  logic [ACC_WIDTH-1:0]   r_acc [LANES];
  logic [ACC_WIDTH-1:0]   w_sum [LANES];
  logic [ACC_WIDTH-1:0]   w_base [LANES];
  logic [ACC_WIDTH:0]     w_wide [LANES];
  logic [ACC_WIDTH-1:0]   w_acc_nxt [LANES];
  logic [LANES-1:0]       w_clip;
  logic                   w_all_v, w_s2_take, w_s1_adv, w_fire, w_hs, w_wrap;
  logic [15:0]            w_out_cnt_nxt;
  logic [7:0]             w_pn;

  function automatic logic [ACC_WIDTH-1:0] sext(input logic [PSUM_WIDTH-1:0] v);
    return {{(ACC_WIDTH-PSUM_WIDTH){v[PSUM_WIDTH-1]}}, v};
  endfunction

  assign cfg_ready     = r_state == IDLE;
  assign w_pn          = (cfg_pass_num == 8'd0) ? 8'd1 : cfg_pass_num;
  assign w_all_v       = &(col_valid | ~r_mask);
  assign w_hs          = out_valid & out_ready;
  assign w_s2_take     = r_s1_valid & (~out_valid | out_ready);
  assign w_s1_adv      = ~r_s1_valid | w_s2_take;
  assign w_fire        = rst_n & (r_state == RUN) & w_all_v & w_s1_adv & (r_issued < r_total);
  assign col_ready     = {NUM_COL{w_fire}} & r_mask;
  assign w_wrap        = w_s2_take & (r_pass_cnt == r_pass_num - 8'd1);
  assign w_out_cnt_nxt = r_out_cnt + 16'(w_hs);

  // Clamp keeps the wide sum's sign and fills the rest with its inverse: min or max of ACC_WIDTH.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_sum[k] = '0;
      for (int j = 0; j < NUM_COL; j++)
        w_sum[k] = w_sum[k] + (r_mask[j] ? sext(col_data[(j*LANES+k)*PSUM_WIDTH +: PSUM_WIDTH]) : '0);
      w_base[k]    = (r_pass_cnt == 8'd0) ? '0 : r_acc[k];
      w_wide[k]    = {w_base[k][ACC_WIDTH-1], w_base[k]} + {r_s1_data[k][ACC_WIDTH-1], r_s1_data[k]};
      w_clip[k]    = r_sat_en & (w_wide[k][ACC_WIDTH] ^ w_wide[k][ACC_WIDTH-1]);
      w_acc_nxt[k] = ~w_clip[k] ? w_wide[k][ACC_WIDTH-1:0]
                                : {w_wide[k][ACC_WIDTH], {(ACC_WIDTH-1){~w_wide[k][ACC_WIDTH]}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_mask     <= '0;
      r_pass_num <= 8'd1;
      r_out_num  <= '0;
      r_sat_en   <= 1'b0;
      r_total    <= '0;
      r_issued   <= '0;
      r_pass_cnt <= '0;
      r_out_cnt  <= '0;
      r_s1_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      sat_flag   <= 1'b0;
      finish     <= 1'b0;
    end else begin
      finish <= r_state == DONE;
      if (r_state == IDLE && cfg_valid) begin
        r_mask     <= cfg_col_mask;
        r_pass_num <= w_pn;
        r_out_num  <= cfg_out_num;
        r_sat_en   <= cfg_sat_en;
        r_total    <= 24'(cfg_out_num) * 24'(w_pn);
        r_issued   <= '0;
        r_pass_cnt <= '0;
        r_out_cnt  <= '0;
        sat_flag   <= 1'b0;
        r_state    <= (cfg_out_num == 16'd0 || cfg_col_mask == '0) ? DONE : RUN;
      end else if (r_state == DONE)
        r_state <= IDLE;
      else if (r_state == RUN && w_hs && out_last)
        r_state <= DONE;
      if (w_fire)
        r_issued <= r_issued + 24'd1;
      if (w_s1_adv)
        r_s1_valid <= w_fire;
      if (w_fire)
        r_s1_data <= w_sum;
      if (w_s2_take) begin
        r_acc      <= w_acc_nxt;
        r_pass_cnt <= w_wrap ? 8'd0 : r_pass_cnt + 8'd1;
        if (|w_clip)
          sat_flag <= 1'b1;
      end
      if (w_hs)
        r_out_cnt <= w_out_cnt_nxt;
      if (w_wrap) begin
        out_valid <= 1'b1;
        out_last  <= w_out_cnt_nxt == r_out_num - 16'd1;
        for (int k = 0; k < LANES; k++)
          out_data[k*ACC_WIDTH +: ACC_WIDTH] <= w_acc_nxt[k];
      end else if (w_hs)
        out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_psum_reduce_accum.sv
// tb_psum_reduce_accum: random column streams and backpressure against an integer model of
// the masked sum and pass-group accumulation, with literal pins on the directed cases.
module tb_psum_reduce_accum;
  localparam int NC = 4;
  localparam int L  = 18;
  localparam int PW = 16;
  localparam int AW = 24;
  localparam longint AMAX = (longint'(1) <<< (AW-1)) - 1;
  localparam longint AMIN = -(longint'(1) <<< (AW-1));

  logic              clk = 0, rst_n = 0, cfg_valid = 0, cfg_sat_en = 0, out_ready = 0;
  logic              cfg_ready, out_valid, out_last, sat_flag, finish;
  logic [NC-1:0]     cfg_col_mask = '0, col_valid = '0, col_ready;
  logic [7:0]        cfg_pass_num = '0;
  logic [15:0]       cfg_out_num = '0;
  logic [NC*L*PW-1:0] col_data = '0;
  logic [L*AW-1:0]   out_data;

  typedef struct { logic [L*AW-1:0] d; logic last; } exp_t;
  exp_t            exp_q[$];
  exp_t            cmp_e;
  logic [L*PW-1:0] cq [NC][$];
  int              n_cmp = 0, n_bad = 0, cyc = 0, exp_fin = -1, first_fire = -1, first_out = -1;
  logic [NC-1:0]   act_mask = '0;
  logic            prev_stall = 0, exp_sat = 0, fin_seen = 0;
  logic [L*AW-1:0] prev_data = '0, last_data = '0;
  logic signed [AW-1:0] lane_v;

  psum_reduce_accum dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_col_mask(cfg_col_mask), .cfg_pass_num(cfg_pass_num), .cfg_out_num(cfg_out_num),
    .cfg_sat_en(cfg_sat_en), .col_valid(col_valid), .col_data(col_data), .col_ready(col_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .sat_flag(sat_flag), .finish(finish)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_vec(input string name, input logic [L*AW-1:0] act, input logic [L*AW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n)
      prev_stall = 0;
    else begin
      if (col_ready != '0) begin
        check("col_ready_masked", longint'(col_ready & ~act_mask), 0);
        check("col_ready_without_valid", longint'(col_ready & ~col_valid), 0);
        if (first_fire < 0) first_fire = cyc;
      end
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1);
        check_vec("stall_data_held", out_data, prev_data);
      end
      if (out_valid && first_out < 0) first_out = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 1, 0);
        else begin
          cmp_e = exp_q.pop_front();
          check_vec("out_data", out_data, cmp_e.d);
          check("out_last", out_last, cmp_e.last);
          if (cmp_e.last) exp_fin = cyc + 2;
        end
        last_data = out_data;
      end
      if (cfg_valid && cfg_ready && (cfg_out_num == 0 || cfg_col_mask == '0)) exp_fin = cyc + 2;
      if (finish || cyc == exp_fin) check("finish_pulse", finish && cyc == exp_fin, 1);
      if (finish) fin_seen = 1;
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
    end
  end

  function automatic logic [PW-1:0] gen(input int mode, input int j, input int k);
    case (mode)
      1:       return PW'(k + 1);
      2:       return (j == 0) ? 16'd1 : (j == 2) ? 16'd2 : 16'd100;
      3:       return 16'h7fff;
      default: return PW'($urandom);
    endcase
  endfunction

  task automatic tick(input int gap, input int rdy);
    logic [NC-1:0] pops;
    @(negedge clk);
    pops = col_ready;
    @(posedge clk);
    #1;
    cfg_valid = 0;
    for (int j = 0; j < NC; j++) begin
      if (pops[j] && cq[j].size() > 0) void'(cq[j].pop_front());
      if (act_mask[j]) begin
        col_valid[j] = cq[j].size() > 0 && $urandom_range(99) >= gap;
        col_data[j*L*PW +: L*PW] = (cq[j].size() > 0) ? cq[j][0] : '0;
      end else begin
        col_valid[j] = 1'($urandom_range(1));
        for (int k = 0; k < L; k++) col_data[(j*L+k)*PW +: PW] = PW'($urandom);
      end
    end
    out_ready = $urandom_range(99) < rdy;
  endtask

  task automatic run_job(input logic [NC-1:0] mask, input int pass, input int outs, input logic sat,
                         input int mode, input int gap, input int rdy, input bit stop_at_valid);
    int              pe = (pass == 0) ? 1 : pass;
    bit              degen = (outs == 0) || (mask == '0);
    longint          acc[L];
    longint          sums[L];
    logic [L*PW-1:0] vec;
    logic [PW-1:0]   val;
    shortint         sv;
    exp_t            e;
    int              n, left;
    exp_q.delete();
    for (int j = 0; j < NC; j++) cq[j].delete();
    exp_sat = 0; fin_seen = 0; first_fire = -1; first_out = -1; exp_fin = -1;
    if (!degen)
      for (int g = 0; g < outs; g++) begin
        for (int k = 0; k < L; k++) acc[k] = 0;
        for (int p = 0; p < pe; p++) begin
          for (int k = 0; k < L; k++) sums[k] = 0;
          for (int j = 0; j < NC; j++)
            if (mask[j]) begin
              for (int k = 0; k < L; k++) begin
                val = gen(mode, j, k);
                vec[k*PW +: PW] = val;
                sv = shortint'(val);
                sums[k] += longint'(sv);
              end
              cq[j].push_back(vec);
            end
          for (int k = 0; k < L; k++) begin
            acc[k] += sums[k];
            if (sat && acc[k] > AMAX) begin acc[k] = AMAX; exp_sat = 1; end
            else if (sat && acc[k] < AMIN) begin acc[k] = AMIN; exp_sat = 1; end
            else if (!sat) begin
              acc[k] = acc[k] & ((longint'(1) <<< AW) - 1);
              if (acc[k] > AMAX) acc[k] -= longint'(1) <<< AW;
            end
          end
        end
        for (int k = 0; k < L; k++) e.d[k*AW +: AW] = AW'(acc[k]);
        e.last = (g == outs - 1);
        exp_q.push_back(e);
      end
    act_mask = degen ? '0 : mask;
    n = 0;
    while (!cfg_ready && n < 50) begin tick(gap, rdy); n++; end
    cfg_col_mask = mask; cfg_pass_num = 8'(pass); cfg_out_num = 16'(outs); cfg_sat_en = sat;
    cfg_valid = 1;
    n = 0;
    while (!fin_seen && n < 20000) begin
      tick(gap, rdy);
      n++;
      if (stop_at_valid && out_valid) return;
    end
    if (!fin_seen) check("job_timeout", 1, 0);
    check("outputs_outstanding", exp_q.size(), 0);
    left = 0;
    for (int j = 0; j < NC; j++) left += cq[j].size();
    check("columns_undrained", left, 0);
    check("sat_flag", sat_flag, exp_sat);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check_vec("rst_out_data", out_data, '0);
    check("rst_out_last", out_last, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_finish", finish, 0);
    check("rst_col_ready", col_ready, 0);
    rst_n = 1;
    #1;
    check("rst_cfg_ready", cfg_ready, 1);

    run_job(4'b1111, 1, 3, 0, 1, 0, 100, 0);
    check("T1_latency", first_out - first_fire, 2);
    lane_v = last_data[0 +: AW];        check("T1_lane0", lane_v, 4);
    lane_v = last_data[17*AW +: AW];    check("T1_lane17", lane_v, 72);

    run_job(4'b0101, 4, 2, 0, 2, 0, 100, 0);
    lane_v = last_data[0 +: AW];        check("T2_lane0", lane_v, 12);
    lane_v = last_data[17*AW +: AW];    check("T2_lane17", lane_v, 12);

    run_job(4'b1111, 255, 1, 1, 3, 0, 100, 0);
    lane_v = last_data[5*AW +: AW];     check("T3_sat_lane", lane_v, 8388607);
    check("T3_sat_flag_set", sat_flag, 1);
    run_job(4'b1111, 255, 1, 0, 3, 0, 100, 0);
    lane_v = last_data[5*AW +: AW];     check("T3_wrap_lane", lane_v, -132092);
    check("T3_wrap_flag_clear", sat_flag, 0);

    run_job(4'b1111, 2, 100, 0, 0, 30, 50, 0);
    run_job(4'b1011, 0, 40, 1, 0, 20, 50, 0);
    run_job(4'b0010, 3, 20, 1, 0, 40, 60, 0);

    run_job(4'b1111, 1, 0, 0, 0, 0, 100, 0);
    check("T5_no_output", first_out, -1);
    run_job(4'b0000, 1, 3, 0, 0, 0, 100, 0);
    check("T5_mask0_no_output", first_out, -1);

    run_job(4'b1111, 3, 5, 0, 0, 0, 0, 1);
    check("T6_valid_before_reset", out_valid, 1);
    rst_n = 0;
    @(negedge clk);
    check("T6_col_ready_in_reset", col_ready, 0);
    @(posedge clk);
    #1;
    check("T6_out_valid_cleared", out_valid, 0);
    check_vec("T6_out_data_cleared", out_data, '0);
    exp_q.delete();
    for (int j = 0; j < NC; j++) cq[j].delete();
    act_mask = '0;
    exp_fin = -1;
    rst_n = 1;
    #1;
    check("T6_cfg_ready", cfg_ready, 1);
    run_job(4'b0110, 1, 12, 0, 0, 10, 70, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
